dcache_axi_arbiter: RTL

- Shares the single-beat, single-outstanding dcache AXI master between NUM_PORTS dcache-side requesters, e.g. refill read, victim writeback and uncached load/store.
- Selects one requester and issues its transaction to the master as a one-cycle new_request pulse.
- Holds off all other requesters until the master reports completion, then routes the response back to the requester that issued it.
- Sits between the dcache miss/writeback logic and the AXI dcache master.

---
 rtl/dcache_axi_arbiter.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/dcache_axi_arbiter.sv
// Arbitrates NUM_PORTS dcache requesters onto the single-outstanding AXI dcache master.
// Define DCACHE_ARB_RR_EN for round-robin selection; otherwise the lowest index wins.
`timescale 1ns/1ps
module dcache_axi_arbiter #(
  parameter int NUM_PORTS  = 2,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 128
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [NUM_PORTS-1:0]              req_valid,
  input  logic [NUM_PORTS-1:0]              req_we,
  input  logic [NUM_PORTS-1:0]              req_uncached,
  input  logic [NUM_PORTS*ADDR_WIDTH-1:0]   req_addr,
  input  logic [NUM_PORTS*3-1:0]            req_size,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0]   req_wdata,
  input  logic [NUM_PORTS*DATA_WIDTH/8-1:0] req_wstrb,
  output logic [NUM_PORTS-1:0]              req_accept,
  output logic [NUM_PORTS-1:0]              resp_valid,
  output logic [DATA_WIDTH-1:0]             resp_rdata,
  output logic                              mst_new_request,
  output logic                              mst_we,
  output logic                              mst_uncached,
  output logic [ADDR_WIDTH-1:0]             mst_addr,
  output logic [2:0]                        mst_size,
  output logic [DATA_WIDTH-1:0]             mst_wdata,
  output logic [DATA_WIDTH/8-1:0]           mst_wstrb,
  input  logic                              mst_ready,
  input  logic                              mst_rvalid,
  input  logic                              mst_wvalid,
  input  logic [DATA_WIDTH-1:0]             mst_rdata
);

  localparam int IDW    = $clog2(NUM_PORTS);
  localparam int CW     = IDW + 1;
  localparam int STRB_W = DATA_WIDTH / 8;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_WAIT = 1'b1;

  logic [0:0]            state_r;
  logic [IDW-1:0]        gnt_id_r;
  logic                  gnt_we_r;
  logic [IDW-1:0]        sel_s;
  logic                  issue_s;
  logic                  done_s;

  logic                  we_r;
  logic                  uncached_r;
  logic [ADDR_WIDTH-1:0] addr_r;
  logic [2:0]            size_r;
  logic [DATA_WIDTH-1:0] wdata_r;
  logic [STRB_W-1:0]     wstrb_r;

  // rst gates both strobes so nothing leaks out while the synchronous reset is pending
  assign issue_s = !rst && (state_r == ST_IDLE) && (|req_valid) && mst_ready;
  assign done_s  = !rst && (state_r == ST_WAIT) && (gnt_we_r ? mst_wvalid : mst_rvalid);

`ifdef DCACHE_ARB_RR_EN
  logic [IDW-1:0] rr_ptr_r;

  // round-robin pick: first valid port scanning upward from rr_ptr_r with wrap
  always_comb begin : rr_select
    logic [CW-1:0] cand_v;
    logic          found_v;
    sel_s   = '0;
    found_v = 1'b0;
    cand_v  = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      cand_v = {1'b0, rr_ptr_r} + CW'(i);
      if (cand_v >= CW'(NUM_PORTS)) begin
        cand_v = cand_v - CW'(NUM_PORTS);
      end else begin
        cand_v = cand_v;
      end
      if (!found_v && req_valid[cand_v[IDW-1:0]]) begin
        found_v = 1'b1;
        sel_s   = cand_v[IDW-1:0];
      end else begin
        found_v = found_v;
      end
    end
  end

  // pointer moves just past the port that was granted
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr_r <= '0;
    end else if (issue_s) begin
      rr_ptr_r <= (sel_s == IDW'(NUM_PORTS - 1)) ? '0 : sel_s + IDW'(1);
    end
  end
`else
  // fixed priority: scan downward so the lowest valid index is the last write
  always_comb begin
    sel_s = '0;
    for (int i = NUM_PORTS - 1; i >= 0; i--) begin
      if (req_valid[i]) begin
        sel_s = IDW'(i);
      end else begin
        sel_s = sel_s;
      end
    end
  end
`endif

  // grant FSM plus hold registers for the last issued master fields
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= ST_IDLE;
      gnt_id_r   <= '0;
      gnt_we_r   <= 1'b0;
      we_r       <= 1'b0;
      uncached_r <= 1'b0;
      addr_r     <= '0;
      size_r     <= 3'd0;
      wdata_r    <= '0;
      wstrb_r    <= '0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (issue_s) begin
            state_r  <= ST_WAIT;
            gnt_id_r <= sel_s;
            gnt_we_r <= req_we[sel_s];
          end
        end
        ST_WAIT: begin
          if (done_s) begin
            state_r <= ST_IDLE;
          end
        end
        default: state_r <= ST_IDLE;
      endcase
      if (issue_s) begin
        we_r       <= req_we[sel_s];
        uncached_r <= req_uncached[sel_s];
        addr_r     <= req_addr[sel_s*ADDR_WIDTH +: ADDR_WIDTH];
        size_r     <= req_size[sel_s*3 +: 3];
        wdata_r    <= req_wdata[sel_s*DATA_WIDTH +: DATA_WIDTH];
        wstrb_r    <= req_wstrb[sel_s*STRB_W +: STRB_W];
      end
    end
  end

  // same-cycle issue/response strobes; master fields bypass the hold registers on issue
  always_comb begin
    req_accept      = '0;
    resp_valid      = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      req_accept[p] = issue_s && (sel_s == IDW'(p));
      resp_valid[p] = done_s && (gnt_id_r == IDW'(p));
    end
    resp_rdata      = done_s ? mst_rdata : '0;
    mst_new_request = issue_s;
    if (issue_s) begin
      mst_we       = req_we[sel_s];
      mst_uncached = req_uncached[sel_s];
      mst_addr     = req_addr[sel_s*ADDR_WIDTH +: ADDR_WIDTH];
      mst_size     = req_size[sel_s*3 +: 3];
      mst_wdata    = req_wdata[sel_s*DATA_WIDTH +: DATA_WIDTH];
      mst_wstrb    = req_wstrb[sel_s*STRB_W +: STRB_W];
    end else begin
      mst_we       = we_r;
      mst_uncached = uncached_r;
      mst_addr     = addr_r;
      mst_size     = size_r;
      mst_wdata    = wdata_r;
      mst_wstrb    = wstrb_r;
    end
  end

endmodule
